// File: rtl/drivers_conf_pkg.sv
// Shared types and defaults for the TLC5957 driver configuration path.
package drivers_conf_pkg;
  localparam int CONF_WIDTH = 48;
  localparam logic [CONF_WIDTH-1:0] DEFAULT_CONF = 48'h4A5A_0F1E_7C3D;

  typedef enum logic [1:0] {IDLE, WAIT_READY, COMMIT, HOLDOFF} conf_sched_state_t;
  typedef enum logic {SRC_SPI, SRC_DBG} conf_src_t;
endpackage

// File: rtl/conf_request_slot.sv
// One-deep pending request buffer; a new request always replaces the old one.
module conf_request_slot #(
  parameter int              W         = 48,
  parameter bit              BOOT_PEND = 1'b0,
  parameter logic [W-1:0]    BOOT_DATA = '0
) (
  input  logic         clk_33,
  input  logic         nrst,
  input  logic         set,
  input  logic [W-1:0] data_in,
  input  logic         clear,
  output logic         pend,
  output logic [W-1:0] data_out,
  output logic         overwrite
);
  always_ff @(posedge clk_33 or negedge nrst) begin
    if (!nrst) begin
      pend     <= BOOT_PEND;
      data_out <= BOOT_DATA;
    end else if (set) begin
      pend     <= 1'b1;
      data_out <= data_in;
    end else if (clear) begin
      pend     <= 1'b0;
    end
  end

  // A request landing on the cycle its predecessor is granted is not a loss.
  assign overwrite = set & pend & ~clear;
endmodule

// File: rtl/driver_conf_scheduler.sv
// Round-robin scheduler of SPI/debug configuration words toward driver_controller.
module driver_conf_scheduler #(
  parameter int                    CONF_WIDTH     = drivers_conf_pkg::CONF_WIDTH,
  parameter int                    HOLDOFF_CYCLES = 64,
  parameter logic [CONF_WIDTH-1:0] DEFAULT_CONF   = drivers_conf_pkg::DEFAULT_CONF,
  parameter bit                    BOOT_LOAD      = 1'b1
) (
  input  logic                  clk_33,
  input  logic                  nrst,
  input  logic [CONF_WIDTH-1:0] spi_conf,
  input  logic                  spi_conf_valid,
  input  logic [CONF_WIDTH-1:0] dbg_conf,
  input  logic                  dbg_conf_valid,
  input  logic                  dbg_restore,
  input  logic                  driver_ready,
  output logic [CONF_WIDTH-1:0] serialized_conf,
  output logic                  new_configuration_ready,
  output logic                  busy,
  output logic                  overrun,
  output logic                  last_src
);
  import drivers_conf_pkg::*;

  localparam int CW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  conf_sched_state_t     state, state_nxt;
  conf_src_t             src_q;
  logic [CW-1:0]         cnt;
  logic                  spi_pend, dbg_pend, spi_ow, dbg_ow;
  logic                  grant_spi, grant_dbg, dbg_set;
  logic [CONF_WIDTH-1:0] spi_data, dbg_data, dbg_in;

  assign dbg_set = dbg_conf_valid | dbg_restore;
  assign dbg_in  = dbg_restore ? DEFAULT_CONF : dbg_conf;

  conf_request_slot #(.W(CONF_WIDTH), .BOOT_PEND(1'b0), .BOOT_DATA(DEFAULT_CONF)) u_spi_slot (
    .clk_33(clk_33), .nrst(nrst), .set(spi_conf_valid), .data_in(spi_conf),
    .clear(grant_spi), .pend(spi_pend), .data_out(spi_data), .overwrite(spi_ow)
  );

  conf_request_slot #(.W(CONF_WIDTH), .BOOT_PEND(BOOT_LOAD), .BOOT_DATA(DEFAULT_CONF)) u_dbg_slot (
    .clk_33(clk_33), .nrst(nrst), .set(dbg_set), .data_in(dbg_in),
    .clear(grant_dbg), .pend(dbg_pend), .data_out(dbg_data), .overwrite(dbg_ow)
  );

  always_ff @(posedge clk_33 or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_spi = 1'b0;
    grant_dbg = 1'b0;
    case (state)
      IDLE: begin
        // With both pending, the source not served last goes first.
        if (dbg_pend && (!spi_pend || src_q == SRC_SPI)) begin
          grant_dbg = 1'b1;
          state_nxt = WAIT_READY;
        end else if (spi_pend) begin
          grant_spi = 1'b1;
          state_nxt = WAIT_READY;
        end
      end
      WAIT_READY: if (driver_ready) state_nxt = COMMIT;
      COMMIT:     state_nxt = HOLDOFF;
      HOLDOFF:    if (cnt == '0) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_33 or negedge nrst) begin
    if (!nrst) begin
      serialized_conf <= DEFAULT_CONF;
      src_q           <= SRC_DBG;
      cnt             <= '0;
      overrun         <= 1'b0;
    end else begin
      if (grant_spi) begin
        serialized_conf <= spi_data;
        src_q           <= SRC_SPI;
      end else if (grant_dbg) begin
        serialized_conf <= dbg_data;
        src_q           <= SRC_DBG;
      end
      if (state == COMMIT)                    cnt <= CW'(HOLDOFF_CYCLES - 1);
      else if (state == HOLDOFF && cnt != '0) cnt <= cnt - CW'(1);
      if (spi_ow | dbg_ow) overrun <= 1'b1;
    end
  end

  assign new_configuration_ready = (state == COMMIT);
  assign busy                    = (state != IDLE);
  assign last_src                = (src_q == SRC_DBG);
endmodule

// File: tb/tb_driver_conf_scheduler.sv
// Randomized and directed checks of driver_conf_scheduler against a timeline model.
module tb_driver_conf_scheduler;
  import drivers_conf_pkg::*;

  localparam int              W    = CONF_WIDTH;
  localparam int              HOLD = 64;
  localparam logic [W-1:0]    DEF  = DEFAULT_CONF;

  logic         clk_33 = 1'b0, nrst = 1'b0;
  logic [W-1:0] spi_conf = '0, dbg_conf = '0;
  logic         spi_conf_valid = 1'b0, dbg_conf_valid = 1'b0, dbg_restore = 1'b0;
  logic         driver_ready = 1'b1;

  logic [W-1:0] serialized_conf, serialized_conf0;
  logic         new_configuration_ready, busy, overrun, last_src;
  logic         new_configuration_ready0, busy0, overrun0, last_src0;

  driver_conf_scheduler #(.CONF_WIDTH(W), .HOLDOFF_CYCLES(HOLD), .DEFAULT_CONF(DEF), .BOOT_LOAD(1'b1)) dut (
    .clk_33(clk_33), .nrst(nrst), .spi_conf(spi_conf), .spi_conf_valid(spi_conf_valid),
    .dbg_conf(dbg_conf), .dbg_conf_valid(dbg_conf_valid), .dbg_restore(dbg_restore),
    .driver_ready(driver_ready), .serialized_conf(serialized_conf),
    .new_configuration_ready(new_configuration_ready), .busy(busy), .overrun(overrun),
    .last_src(last_src)
  );

  driver_conf_scheduler #(.CONF_WIDTH(W), .HOLDOFF_CYCLES(HOLD), .DEFAULT_CONF(DEF), .BOOT_LOAD(1'b0)) dut0 (
    .clk_33(clk_33), .nrst(nrst), .spi_conf(spi_conf), .spi_conf_valid(spi_conf_valid),
    .dbg_conf(dbg_conf), .dbg_conf_valid(dbg_conf_valid), .dbg_restore(dbg_restore),
    .driver_ready(driver_ready), .serialized_conf(serialized_conf0),
    .new_configuration_ready(new_configuration_ready0), .busy(busy0), .overrun(overrun0),
    .last_src(last_src0)
  );

  always #15 clk_33 = ~clk_33;

  int n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: pending slots plus a timeline (edge of last commit, edge when idle again).
  int           cyc = 0, free_at = 0, commit_edge = -1;
  bit           mwait, ovr, mlast;
  bit           spend[2];
  logic [W-1:0] sdata[2];
  logic [W-1:0] mconf;

  task automatic mreset();
    spend[0] = 1'b0; spend[1] = 1'b1;
    sdata[0] = DEF;  sdata[1] = DEF;
    ovr = 1'b0; mlast = 1'b1; mconf = DEF;
    mwait = 1'b0; free_at = 0; commit_edge = -1;
  endtask

  task automatic cmp_all();
    check("conf",    64'(serialized_conf), 64'(mconf));
    check("pulse",   64'(new_configuration_ready), 64'(cyc == commit_edge));
    check("busy",    64'(busy), 64'(mwait || (cyc < free_at - 1)));
    check("overrun", 64'(overrun), 64'(ovr));
    check("lastsrc", 64'(last_src), 64'(mlast));
  endtask

  task automatic step();
    int           g;
    bit           stb[2];
    bit           still;
    logic [W-1:0] nd[2];
    @(posedge clk_33);
    cyc++;
    if (!nrst) mreset();
    else begin
      g = -1;
      if (mwait) begin
        if (driver_ready) begin
          mwait = 1'b0; commit_edge = cyc; free_at = cyc + HOLD + 2;
        end
      end else if (cyc >= free_at) begin
        if (spend[0] && spend[1]) g = mlast ? 0 : 1;
        else if (spend[0])        g = 0;
        else if (spend[1])        g = 1;
        if (g >= 0) begin mconf = sdata[g]; mlast = (g == 1); mwait = 1'b1; end
      end
      stb[0] = spi_conf_valid;                 nd[0] = spi_conf;
      stb[1] = dbg_conf_valid | dbg_restore;   nd[1] = dbg_restore ? DEF : dbg_conf;
      for (int s = 0; s < 2; s++) begin
        still = spend[s] && (g != s);
        if (stb[s]) begin
          if (still) ovr = 1'b1;
          spend[s] = 1'b1; sdata[s] = nd[s];
        end else spend[s] = still;
      end
    end
    #1;
    cmp_all();
  endtask

  task automatic req(input bit s, input logic [W-1:0] sd, input bit d, input logic [W-1:0] dd, input bit r);
    spi_conf_valid = s; spi_conf = sd; dbg_conf_valid = d; dbg_conf = dd; dbg_restore = r;
    step();
    spi_conf_valid = 1'b0; dbg_conf_valid = 1'b0; dbg_restore = 1'b0;
  endtask

  task automatic quiet();
    int n;
    n = 0;
    driver_ready = 1'b1;
    while ((mwait || cyc < free_at || spend[0] || spend[1]) && n < 300) begin step(); n++; end
    if (n >= 300) check("quiet_timeout", 64'd1, 64'd0);
  endtask

  logic [W-1:0] a, b, x;
  int           n;

  initial begin
    mreset();
    #20;
    cmp_all();
    check("rst_conf0", 64'(serialized_conf0), 64'(DEF));
    check("rst_busy0", 64'(busy0), 64'd0);
    @(negedge clk_33); nrst = 1'b1;

    // Boot load of the default word.
    step(); check("boot_conf", 64'(serialized_conf), 64'(DEF));
    step(); check("boot_pulse", 64'(new_configuration_ready), 64'd1);
    check("boot_src", 64'(last_src), 64'd1);
    repeat (HOLD + 1) step();
    check("boot_busy", 64'(busy), 64'd0);

    // Simultaneous SPI and debug with last_src = debug: SPI first.
    a = W'({$urandom(), $urandom()}); b = W'({$urandom(), $urandom()});
    req(1'b1, a, 1'b1, b, 1'b0);
    step(); check("rr_first", 64'(serialized_conf), 64'(a)); check("rr_src0", 64'(last_src), 64'd0);
    repeat (HOLD + 2) step(); check("rr_hold", 64'(serialized_conf), 64'(a));
    step(); check("rr_second", 64'(serialized_conf), 64'(b)); check("rr_src1", 64'(last_src), 64'd1);

    // Single SPI request latency.
    quiet();
    req(1'b1, 48'h0123_4567_89AB, 1'b0, '0, 1'b0);
    step(); check("lat_nopulse", 64'(new_configuration_ready), 64'd0);
    step(); check("lat_pulse", 64'(new_configuration_ready), 64'd1);
    check("lat_conf", 64'(serialized_conf), 64'h0123_4567_89AB);
    check("lat_src", 64'(last_src), 64'd0);

    // Commit waits on driver_ready.
    quiet();
    driver_ready = 1'b0;
    x = W'({$urandom(), $urandom()});
    req(1'b1, x, 1'b0, '0, 1'b0);
    repeat (101) step();
    check("rdy_hold", 64'(serialized_conf), 64'(x));
    driver_ready = 1'b1;
    step(); check("rdy_pulse", 64'(new_configuration_ready), 64'd1);

    // Two SPI strobes during hold-off: last wins, overrun sticks.
    quiet();
    x = W'({$urandom(), $urandom()}); a = W'({$urandom(), $urandom()}); b = W'({$urandom(), $urandom()});
    req(1'b1, x, 1'b0, '0, 1'b0);
    repeat (3) step();
    req(1'b1, a, 1'b0, '0, 1'b0);
    req(1'b1, b, 1'b0, '0, 1'b0);
    check("ovr_set", 64'(overrun), 64'd1);
    n = 0;
    while (!new_configuration_ready && n < 200) begin step(); n++; end
    check("ovr_conf", 64'(serialized_conf), 64'(b));
    quiet(); repeat (10) step();
    check("ovr_sticky", 64'(overrun), 64'd1);

    // Reset in WAIT_READY with debug pending.
    driver_ready = 1'b0;
    req(1'b1, W'({$urandom(), $urandom()}), 1'b0, '0, 1'b0);
    step();
    req(1'b0, '0, 1'b1, W'({$urandom(), $urandom()}), 1'b0);
    step();
    nrst = 1'b0; #1;
    mreset(); cmp_all();
    check("wr_rst_ovr0",  64'(overrun0), 64'd0);
    check("wr_rst_busy0", 64'(busy0), 64'd0);
    check("wr_rst_src0",  64'(last_src0), 64'd1);
    #10; nrst = 1'b1; driver_ready = 1'b1;
    repeat (100) begin
      step();
      check("noboot_pulse0", 64'(new_configuration_ready0), 64'd0);
      check("noboot_busy0",  64'(busy0), 64'd0);
    end

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      spi_conf_valid = ($urandom_range(0, 19) == 0);
      spi_conf       = W'({$urandom(), $urandom()});
      dbg_conf_valid = ($urandom_range(0, 29) == 0);
      dbg_conf       = W'({$urandom(), $urandom()});
      dbg_restore    = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 39) == 0) driver_ready = ~driver_ready;
      else if ($urandom_range(0, 7) == 0) driver_ready = 1'b1;
      if ($urandom_range(0, 999) == 0) nrst = 1'b0;
      step();
      nrst = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
